// File: rtl/j_mtxresp.sv
// j_mtxresp: responder end of the matrix-operand fetch handshake.
// It shares one synchronous local-RAM port between matrix long-word reads
// and CPU load/store accesses. Matrix fetches have priority, but the number
// of consecutive matrix grants is bounded while the CPU is waiting.
module j_mtxresp #(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int MTX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          mtx_mreq,
    input  logic [AW-1:0] mtxaddr,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [DW-1:0] ram_dout,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    output logic          ram_wr,
    output logic [DW-1:0] ram_din,
    output logic          datack,
    output logic [DW-1:0] mtx_data,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata
);

    typedef enum logic [1:0] {IDLE, MTX, CPU} state_t;

    localparam logic [3:0] BURST = 4'(MTX_BURST);

    state_t        state, state_nxt;
    logic [3:0]    streak, streak_nxt;
    logic          mtx_pend, cpu_pend;
    logic          mtx_grant, cpu_grant;
    logic          cpu_rd_p1;
    logic [DW-1:0] mtx_hold, cpu_hold;

    // A requester is not pending in its own ack cycle, so a completing
    // access is never granted twice. Reset blocks all grants so the RAM
    // strobes stay low while reset_n is asserted.
    assign mtx_pend  = mtx_mreq & ~datack & reset_n;
    assign cpu_pend  = cpu_req & ~cpu_ack & reset_n;
    assign cpu_grant = cpu_pend & (~mtx_pend | (streak == BURST));
    assign mtx_grant = mtx_pend & ~cpu_grant;

    assign ram_addr  = mtx_grant ? mtxaddr : cpu_addr;
    assign ram_rd    = mtx_grant | (cpu_grant & ~cpu_wr);
    assign ram_wr    = cpu_grant & cpu_wr;
    assign ram_din   = cpu_wdata;

    // Read data is passed straight through in the ack cycle and held after.
    assign mtx_data  = datack ? ram_dout : mtx_hold;
    assign cpu_rdata = (cpu_ack & cpu_rd_p1) ? ram_dout : cpu_hold;

    // Next grant state and matrix streak length.
    always_comb begin
        state_nxt  = IDLE;
        streak_nxt = streak;
        if (mtx_grant)
            state_nxt = MTX;
        else if (cpu_grant)
            state_nxt = CPU;

        if (cpu_grant || !cpu_req) begin
            streak_nxt = 4'd0;
        end else if (mtx_grant && (streak < BURST)) begin
            case (state)
                CPU:     streak_nxt = 4'd1;
                default: streak_nxt = streak + 4'd1;
            endcase
        end
    end

    // Grant state, streak counter and registered acknowledges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            streak    <= 4'd0;
            datack    <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rd_p1 <= 1'b0;
        end else begin
            state     <= state_nxt;
            streak    <= streak_nxt;
            datack    <= mtx_grant;
            cpu_ack   <= cpu_grant;
            cpu_rd_p1 <= cpu_grant & ~cpu_wr;
        end
    end

    // Operand hold registers capture RAM data in their ack cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtx_hold <= '0;
            cpu_hold <= '0;
        end else begin
            if (datack)
                mtx_hold <= ram_dout;
            if (cpu_ack && cpu_rd_p1)
                cpu_hold <= ram_dout;
        end
    end

endmodule

// File: tb/tb_j_mtxresp.sv
// Bench for j_mtxresp: directed scenarios followed by randomized traffic,
// all checked against a transaction-level reference model of the arbiter
// and a reference copy of RAM contents.
module tb_j_mtxresp;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int BURST = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          mtx_mreq;
    logic [AW-1:0] mtxaddr;
    logic          cpu_req;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] ram_dout;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic          ram_wr;
    logic [DW-1:0] ram_din;
    logic          datack;
    logic [DW-1:0] mtx_data;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic          m_datack, m_cack;
    int            m_streak;
    logic [DW-1:0] m_mtx_val, m_cpu_val;

    j_mtxresp #(.AW(AW), .DW(DW), .MTX_BURST(BURST)) dut (
        .clk(clk), .reset_n(reset_n),
        .mtx_mreq(mtx_mreq), .mtxaddr(mtxaddr),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr),
        .ram_din(ram_din), .datack(datack), .mtx_data(mtx_data),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM driven by the DUT
    always @(posedge clk) begin
        if (ram_wr) ram_mem[ram_addr] <= ram_din;
        if (ram_rd) ram_dout <= ram_mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_datack  = 1'b0;
        m_cack    = 1'b0;
        m_streak  = 0;
        m_mtx_val = '0;
        m_cpu_val = '0;
    endtask

    // One clock cycle: inputs were set at the preceding negedge.
    task automatic cycle();
        logic mp, cp, mg, cg;
        #1;
        mp = mtx_mreq && !m_datack;
        cp = cpu_req && !m_cack;
        cg = cp && (!mp || m_streak == BURST);
        mg = mp && !cg;
        chk("ram_rd", 32'(ram_rd), 32'(mg || (cg && !cpu_wr)));
        chk("ram_wr", 32'(ram_wr), 32'(cg && cpu_wr));
        if (mg) chk("ram_addr_mtx", 32'(ram_addr), 32'(mtxaddr));
        if (cg) chk("ram_addr_cpu", 32'(ram_addr), 32'(cpu_addr));
        if (cg && cpu_wr) chk("ram_din", ram_din, cpu_wdata);
        // Transaction-level effect of this cycle's grant
        if (mg) m_mtx_val = ref_mem[mtxaddr];
        if (cg && !cpu_wr) m_cpu_val = ref_mem[cpu_addr];
        if (cg && cpu_wr) ref_mem[cpu_addr] = cpu_wdata;
        if (cg || !cpu_req) m_streak = 0;
        else if (mg && m_streak < BURST) m_streak++;
        m_datack = mg;
        m_cack   = cg;
        @(posedge clk);
        #1;
        chk("datack", 32'(datack), 32'(m_datack));
        chk("cpu_ack", 32'(cpu_ack), 32'(m_cack));
        chk("mtx_data", mtx_data, m_mtx_val);
        chk("cpu_rdata", cpu_rdata, m_cpu_val);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ram_rd"}, 32'(ram_rd), 32'd0);
        chk({tag, "_ram_wr"}, 32'(ram_wr), 32'd0);
        chk({tag, "_datack"}, 32'(datack), 32'd0);
        chk({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
        chk({tag, "_mtx_data"}, mtx_data, 32'd0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    endtask

    initial begin
        int acks;
        int mgrants;
        logic seen;

        for (int i = 0; i < (1 << AW); i++) begin
            ref_mem[i] = {i[15:0] ^ 16'hA5C3, ~i[15:0]};
        end
        ref_mem[10'h005] = 32'h12345678;
        ref_mem[10'h100] = 32'hCAFE0100;
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = ref_mem[i];
        ram_dout  = '0;

        // Reset with a matrix request already present
        reset_n   = 1'b0;
        mtx_mreq  = 1'b1;
        mtxaddr   = 10'h005;
        cpu_req   = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;
        cycle();
        chk("first_datack", 32'(datack), 32'd1);
        chk("first_mtx_data", mtx_data, 32'h12345678);
        mtx_mreq = 1'b0;
        cycle();
        chk("first_hold", mtx_data, 32'h12345678);

        // Matrix-only stream, controller steps address on datack
        mtx_mreq = 1'b1;
        mtxaddr  = 10'h010;
        acks = 0;
        for (int c = 0; c < 20 && acks < 4; c++) begin
            cycle();
            if (datack) begin
                acks++;
                chk("stream_ack_cycle", 32'(c), 32'(2 * acks - 2));
                if (acks == 4) mtx_mreq = 1'b0;
                else mtxaddr = mtxaddr + 10'd1;
            end
        end
        chk("stream_ack_count", 32'(acks), 32'd4);
        cycle();
        chk("stream_hold", mtx_data, ref_mem[10'h013]);

        // CPU read while the matrix requests continuously
        mtx_mreq = 1'b1;
        mtxaddr  = 10'h030;
        cpu_req  = 1'b1;
        cpu_wr   = 1'b0;
        cpu_addr = 10'h100;
        seen = 1'b0;
        mgrants = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            cycle();
            if (datack) begin
                mgrants++;
                mtxaddr = mtxaddr + 10'd1;
            end
            if (cpu_ack) begin
                seen = 1'b1;
                cpu_req = 1'b0;
                chk("cpu_read_data", cpu_rdata, 32'hCAFE0100);
            end
        end
        if (!seen) chk("cpu_read_timeout", 32'd0, 32'd1);
        chk("cpu_read_mtx_bound", 32'(mgrants <= BURST), 32'd1);
        mtx_mreq = 1'b0;
        cycle();
        chk("cpu_rdata_hold", cpu_rdata, 32'hCAFE0100);

        // CPU write followed by a matrix read of the same word
        cpu_req   = 1'b1;
        cpu_wr    = 1'b1;
        cpu_addr  = 10'h020;
        cpu_wdata = 32'hDEADBEEF;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            cycle();
            if (cpu_ack) begin
                seen = 1'b1;
                cpu_req = 1'b0;
                chk("write_keeps_rdata", cpu_rdata, 32'hCAFE0100);
            end
        end
        if (!seen) chk("cpu_write_timeout", 32'd0, 32'd1);
        mtx_mreq = 1'b1;
        mtxaddr  = 10'h020;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            cycle();
            if (datack) begin
                seen = 1'b1;
                mtx_mreq = 1'b0;
                chk("readback", mtx_data, 32'hDEADBEEF);
            end
        end
        if (!seen) chk("readback_timeout", 32'd0, 32'd1);
        cycle();

        // Simultaneous first requests: matrix first, CPU right after
        mtx_mreq = 1'b1;
        mtxaddr  = 10'h040;
        cpu_req  = 1'b1;
        cpu_wr   = 1'b0;
        cpu_addr = 10'h041;
        cycle();
        chk("simul_mtx_first", 32'({datack, cpu_ack}), 32'b10);
        mtx_mreq = 1'b0;
        cycle();
        chk("simul_cpu_next", 32'({datack, cpu_ack}), 32'b01);
        cpu_req = 1'b0;
        cycle();

        // Reset asserted in a grant cycle
        mtx_mreq = 1'b1;
        mtxaddr  = 10'h050;
        #1;
        chk("pre_reset_rd", 32'(ram_rd), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("in_reset_rd", 32'(ram_rd), 32'd0);
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        mtx_mreq = 1'b0;
        reset_n  = 1'b1;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("post_reset_no_datack", 32'(datack), 32'd0);
        end

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            if (datack) begin
                mtxaddr  = mtxaddr + 10'd1;
                mtx_mreq = ($urandom_range(3) != 0);
            end else if (!mtx_mreq) begin
                mtx_mreq = ($urandom_range(1) != 0);
                mtxaddr  = 10'($urandom_range(63));
            end else if ($urandom_range(9) == 0) begin
                mtx_mreq = 1'b0;
            end
            if (cpu_ack || !cpu_req) begin
                cpu_req   = ($urandom_range(2) == 0);
                cpu_wr    = $urandom_range(1) != 0;
                cpu_addr  = 10'($urandom_range(63));
                cpu_wdata = $urandom;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
